// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Glyph updates are double-buffered and committed only at frame boundaries.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_NEAR = PW'(REFRESH_DIV - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;
    logic [BW-1:0] r_blk_cnt;
    logic          r_blk_phase;
    logic          r_frame_tick;

    logic [NUM_DIGITS-1:0][3:0] r_disp_code;
    logic [NUM_DIGITS-1:0][3:0] r_pend_code;
    logic [NUM_DIGITS-1:0]      r_disp_dp;
    logic [NUM_DIGITS-1:0]      r_disp_blink;
    logic [NUM_DIGITS-1:0]      r_disp_en;
    logic [NUM_DIGITS-1:0]      r_pend_dp;
    logic [NUM_DIGITS-1:0]      r_pend_blink;
    logic [NUM_DIGITS-1:0]      r_pend_en;
    logic                       r_pend_flag;

    logic [NUM_DIGITS-1:0] r_anode;
    logic [7:0]            r_cathode;

    logic                  w_presc_term;
    logic                  w_frame_start;
    logic                  w_tick_next;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [3:0]            w_code;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_anode_next;
    logic [7:0]            w_cath_next;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        glyph = '1;
        case (c)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001001;
            4'hB: glyph = 7'b1111000;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b1000001;
            4'hE: glyph = 7'b1000100;
            4'hF: glyph = 7'b1111111;
        endcase
    endfunction

    assign w_presc_term  = (r_presc == PRE_LAST);
    assign w_frame_start = w_presc_term && (r_idx == IDX_LAST);
    // frame_tick is registered one cycle ahead so it is high during the wrap cycle
    assign w_tick_next   = (r_presc == PRE_NEAR) && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_tick_next;
            if (w_presc_term) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk_cnt   <= '0;
            r_blk_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (r_blk_cnt == BLK_LAST) begin
                r_blk_cnt   <= '0;
                r_blk_phase <= ~r_blk_phase;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_code  <= '1;
            r_disp_dp    <= '0;
            r_disp_blink <= '0;
            r_disp_en    <= '0;
            r_pend_code  <= '1;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_pend_en    <= '0;
            r_pend_flag  <= 1'b0;
        end else if (w_frame_start) begin
            // A load landing on the frame boundary bypasses the pending buffer
            if (load) begin
                r_disp_code  <= codes;
                r_disp_dp    <= dp_en;
                r_disp_blink <= blink_en;
                r_disp_en    <= digit_en;
            end else if (r_pend_flag) begin
                r_disp_code  <= r_pend_code;
                r_disp_dp    <= r_pend_dp;
                r_disp_blink <= r_pend_blink;
                r_disp_en    <= r_pend_en;
            end
            r_pend_flag <= 1'b0;
        end else if (load) begin
            r_pend_code  <= codes;
            r_pend_dp    <= dp_en;
            r_pend_blink <= blink_en;
            r_pend_en    <= digit_en;
            r_pend_flag  <= 1'b1;
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
        w_code          = r_disp_code[r_idx];
        w_blank         = ~r_disp_en[r_idx] | (r_disp_blink[r_idx] & r_blk_phase);
        w_anode_next    = ~(w_onehot & r_disp_en);
        w_cath_next     = w_blank ? 8'hFF : {glyph(w_code), ~r_disp_dp[r_idx]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode   <= '1;
            r_cathode <= 8'hFF;
        end else begin
            r_anode   <= w_anode_next;
            r_cathode <= w_cath_next;
        end
    end

    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display, shared by the traffic-light and counter demos.
- Holds one 4-bit glyph code per digit: decimal 0-9 plus the traffic glyphs (arrows, Y) and blank.
- Scans digits at a programmable refresh rate, supports per-digit decimal point, enable and blink.
- Glyph updates are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new glyphs.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be at least 2.
- BLINK_FRAMES, 64, full frames per blink half-period; must be at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures codes/dp_en/blink_en/digit_en into the pending buffer
- codes  in  4*NUM_DIGITS  glyph code per digit; digit i is codes[4i+3:4i]
- dp_en  in  NUM_DIGITS  decimal point on, per digit
- blink_en  in  NUM_DIGITS  blink enable, per digit
- digit_en  in  NUM_DIGITS  digit enable; a disabled digit's anode stays off
- anode  out  NUM_DIGITS  active-low digit select, registered
- cathode  out  8  active-low segments, registered; [7:1]=a..g, [0]=dp
- frame_tick  out  1  one-cycle pulse at each frame start (scan index wraps to 0)

Behaviour:
- One clock domain. Reset is synchronous and active-high, named reset; clock is clk.
- Reset values:
  - anode all 1s, cathode 8'hFF, frame_tick 0.
  - Prescaler 0, scan index 0, blink phase 0, blink frame counter 0.
  - Display and pending registers: all codes 4'hF, dp/blink/en all 0, pending flag 0.
- Reset mid-scan or mid-load aborts everything; any pending load is discarded.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On the terminal count, scan index advances by 1 and wraps NUM_DIGITS-1 -> 0.
  - The wrap to 0 is a frame start; frame_tick is high for exactly that cycle.
- Output timing:
  - anode and cathode are registered from the current scan index, one cycle of latency after the index changes.
  - anode = ~(onehot(idx) & display_en).
  - cathode[7:1] = glyph(code[idx]); cathode[0] = ~dp[idx].
  - Cathode is forced to 8'hFF when the digit is disabled, or when blink[idx] is set and blink phase = 1.
- Glyph table, code -> a..g, active low:
  - 0: 0000001; 1: 1001111; 2: 0010010; 3: 0000110; 4: 1001100
  - 5: 0100100; 6: 0100000; 7: 0001111; 8: 0000000; 9: 0000100
  - A: 0001001 (up arrow); B: 1111000 (left arrow); C: 1001110 (right arrow)
  - D: 1000001 (down arrow); E: 1000100 (Y); F: 1111111 (blank)
- Double buffer:
  - load copies all four input buses into pending and sets the pending flag. A later load before commit overwrites pending (last wins).
  - At a frame start with the pending flag set, display <= pending and the flag clears.
  - load in the same cycle as a frame start: the inputs go directly to display and the flag stays 0.
  - Committed values drive outputs from the first slot of the new frame.
- Blink:
  - The frame counter counts frame starts 0..BLINK_FRAMES-1.
  - On its wrap, blink phase toggles. Phase and counter are unaffected by load.
- NUM_DIGITS=1: the index is constant 0 and every prescaler wrap is a frame start.
- Counter widths use $clog2, minimum 1 bit.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset: assert reset 3 cycles mid-scan -> anode=4'b1111, cathode=8'hFF, frame_tick=0 on the following cycle; the first frame_tick comes 16 cycles after release.
- Load and scan:
  - Stimulus: load codes=16'hEA21, digit_en=4'hF, dp_en=4'b0010.
  - After the next frame_tick, slots show: digit0 anode 1110 cathode 8'b1001_1111; digit1 anode 1101 cathode 8'b0010_0100 (dp on); digit2 anode 1011 cathode 8'b0001_0011; digit3 anode 0111 cathode 8'b1000_1001; each slot lasts 4 cycles.
- Double buffer:
  - Load 16'h1111 mid-frame, then 16'h2222 two cycles later -> current frame is unchanged; the next frame shows all digits as 8'b0010_0101.
  - Load coincident with frame_tick -> applied in that same frame.
- Blink: blink_en=4'b0001, digit_en=4'hF -> digit0 cathode is 8'hFF for frames 2-3, lit for frames 4-5, and so on; digits 1-3 are never blanked.
- Disable: digit_en=4'b1011 -> during slot 2, anode=4'b1111 and cathode=8'hFF; other slots are normal.
- Reset during a pending load: load, then reset before the frame start -> after reset, all digits stay blank and no commit occurs.
